ifetch_unit: RTL

- Instruction fetch front-end sitting directly upstream of the IF/ID pipeline bank of the segmented TinuC core.
- Replaces the bare PC register and free-running `iaddr` with a latency-tolerant fetch engine: req/gnt/rvalid instruction-memory handshake, in-order prefetch queue, valid/ready output towards decode.
- Accepts a taken-branch redirect from the MEM stage; squashes queued and in-flight instructions.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/ifetch_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch front-end
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - show-ahead prefetch queue of {pc, instr} entries; flush beats push
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && (count_q != '0) && !flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - req/gnt/rvalid instruction fetch engine with prefetch queue feeding IF/ID
// Defining IFETCH_BYPASS_EN lets a response reach decode in its arrival cycle when the queue is empty.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTSTANDING);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] discard_redirect;
  logic [CW-1:0] fifo_count;
  logic [31:0]   target;
  logic          grant, accept, bypass;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  fetch_entry_t  fifo_head, push_entry;

  assign target           = redirect_pc & 32'hFFFF_FFFC;
  assign grant            = imem_req && imem_gnt;
  // A response landing in a redirect cycle belongs to the squashed stream.
  assign accept           = imem_rvalid && (discard_q == '0) && !redirect;
  assign discard_redirect = outstanding_q - CW'(imem_rvalid);
  assign imem_addr        = fpc_q[11:2];
  assign push_entry       = {rpc_q, imem_rdata};

`ifdef IFETCH_BYPASS_EN
  assign bypass = accept && fifo_empty && if_ready;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = accept && !bypass;
  assign fifo_pop  = !fifo_empty && if_ready;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (discard_redirect != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        FLUSH:   state_d = (discard_q == '0) ? RUN : FLUSH;
        default: state_d = BOOT;
      endcase
    end
  end

  // Credit rule: queued plus in-flight entries never exceed the queue depth.
  always_comb begin
    imem_req = 1'b0;
    if ((state_q == RUN) && !redirect && (outstanding_q < MAX_W) &&
        (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_W)) begin
      imem_req = 1'b1;
    end
  end

  always_comb begin
    fpc_d         = fpc_q;
    rpc_d         = rpc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    if (redirect) begin
      fpc_d     = target;
      rpc_d     = target;
      discard_d = discard_redirect;
    end else begin
      if (grant) begin
        fpc_d = fpc_q + 32'd4;
      end
      if (accept) begin
        rpc_d = rpc_q + 32'd4;
      end
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fpc_q         <= RESET_PC;
      rpc_q         <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fpc_q         <= fpc_d;
      rpc_q         <= rpc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_comb begin
    if_valid = 1'b0;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    if (bypass) begin
      if_valid = 1'b1;
      if_instr = imem_rdata;
      if_pc    = rpc_q;
    end else if (!fifo_empty) begin
      if_valid = 1'b1;
      if_instr = fifo_head.instr;
      if_pc    = fifo_head.pc;
    end
  end

  assert property (@(posedge CLK) disable iff (!RESET_N) !(fifo_push && fifo_full));

endmodule
